// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction fetch cache.
package icache_pkg;

    localparam int unsigned LINE_W         = 128;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned OFFS_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [WORD_W-1:0] word_t;

    // Word 0 is the least significant 32 bits of the line.
    function automatic word_t word_sel(input line_t line, input logic [1:0] sel);
        word_t w;
        w = line[31:0];
        case (sel)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = line[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Direct-mapped valid/tag/data arrays with one async read port and one write port.
module icache_tag_store
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned TAG_W     = 26
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_c_o,
    output logic [TAG_W-1:0] rd_tag_c_o,
    output line_t            rd_line_c_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  line_t            wr_line_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    // Flush clears everything; a same-edge fill still marks its own line valid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end
        if (we_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    // Valid bits are the only reset state in the store.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_c_o = valid_q[rd_idx_i];
    assign rd_tag_c_o   = tag_q[rd_idx_i];
    assign rd_line_c_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction cache: single-cycle hits, blocking line fill on miss.
module inst_fetch_cache
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES   = 4,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        pc_req,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic [31:0] Instruction,
    output logic        ins_valid,
    output logic        stall,
    output logic [31:0] InsAddress,
    input  line_t       dataline
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - OFFS_W - IDX_W;
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned PCQ_W = ADDR_W - 2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PCQ_W-1:0]  pc_q, pc_d;
    word_t             ins_q, ins_d;
    logic              ins_valid_q, ins_valid_d;
    logic              stall_q, stall_d;
    logic [31:0]       addr_q, addr_d;
    word_t             fill_word_q, fill_word_d;

    logic              rd_valid_c;
    logic [TAG_W-1:0]  rd_tag_c;
    line_t             rd_line_c;
    logic              hit_c;
    logic              we_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [TAG_W-1:0]  wr_tag_c;
    logic              pc_unused_c;

    assign pc_unused_c = ^PC[1:0];

    // pc_q holds PC[31:2]: bits [1:0] are the word select, then index, then tag.
    assign wr_idx_c = pc_q[IDX_W+1:2];
    assign wr_tag_c = pc_q[PCQ_W-1:IDX_W+2];

    icache_tag_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk_i        (CLK),
        .rst_n_i      (RST_N),
        .flush_i      (flush),
        .rd_idx_i     (PC[IDX_W+3:4]),
        .rd_valid_c_o (rd_valid_c),
        .rd_tag_c_o   (rd_tag_c),
        .rd_line_c_o  (rd_line_c),
        .we_i         (we_c),
        .wr_idx_i     (wr_idx_c),
        .wr_tag_i     (wr_tag_c),
        .wr_line_i    (dataline)
    );

    // A same-cycle flush turns any lookup into a miss.
    assign hit_c = rd_valid_c && (rd_tag_c == PC[31:IDX_W+4]) && !flush;

    // Next-state and output logic for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_valid_d = 1'b0;
        stall_d     = stall_q;
        addr_d      = addr_q;
        fill_word_d = fill_word_q;
        we_c        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_d = 1'b0;
                if (pc_req) begin
                    if (hit_c) begin
                        ins_d       = word_sel(rd_line_c, PC[3:2]);
                        ins_valid_d = 1'b1;
                    end else begin
                        pc_d    = PC[31:2];
                        addr_d  = {4'b0000, PC[31:4]};
                        cnt_d   = '0;
                        stall_d = 1'b1;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    we_c        = 1'b1;
                    fill_word_d = word_sel(dataline, pc_q[1:0]);
                    state_d     = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                ins_d       = fill_word_q;
                ins_valid_d = 1'b1;
                stall_d     = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pc_q        <= '0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            addr_q      <= '0;
            fill_word_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            stall_q     <= stall_d;
            addr_q      <= addr_d;
            fill_word_q <= fill_word_d;
        end
    end

    assign Instruction = ins_q;
    assign ins_valid   = ins_valid_q;
    assign stall       = stall_q;
    assign InsAddress  = addr_q;

endmodule

// File: doc/inst_fetch_cache.md
INST_FETCH_CACHE -- requirements
Module: inst_fetch_cache

Interface
REQ-001 Parameter NUM_LINES, default 4, meaning the number of direct-mapped lines; it SHALL be a power of two, at least 2.
REQ-002 Parameter MEM_LATENCY, default 1, meaning the number of CLK cycles from a stable InsAddress to a valid dataline; it SHALL be at least 1.
REQ-003 Port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port pc_req, input, 1 bit: fetch request from the CPU.
REQ-006 Port PC, input, 32 bits: fetch byte address; PC[1:0] is ignored.
REQ-007 Port flush, input, 1 bit: invalidate all lines.
REQ-008 Port Instruction, output, 32 bits: fetched instruction word.
REQ-009 Port ins_valid, output, 1 bit: one-cycle pulse; Instruction is valid while it is high.
REQ-010 Port stall, output, 1 bit: high while a miss is being serviced.
REQ-011 Port InsAddress, output, 32 bits: line index to instruction memory, equal to zero-extended PC[31:4].
REQ-012 Port dataline, input, 128 bits: line returned by instruction memory.

Function
REQ-013 Address split SHALL be: word select = PC[3:2]; index = PC[3+log2(NUM_LINES):4]; tag = the remaining upper PC bits.
REQ-014 Word 0 SHALL be dataline[31:0] and word 3 SHALL be dataline[127:96], for both the fill capture and the stored line.
REQ-015 The FSM SHALL have exactly three states: IDLE, FILL and RESPOND.
REQ-016 In IDLE, a pc_req that hits (line valid and tag match) SHALL stay in IDLE and register the selected word, with ins_valid high in the next cycle (hit latency 1); stall SHALL stay low.
REQ-017 In IDLE, a pc_req that misses SHALL latch PC, drive InsAddress, raise stall in the next cycle, and go to FILL.
REQ-018 FILL SHALL hold InsAddress constant and count MEM_LATENCY cycles.
REQ-019 On the final FILL cycle, the block SHALL capture dataline into the indexed line, write the tag, set the valid bit, and go to RESPOND.
REQ-020 In RESPOND, Instruction SHALL be the latched word, ins_valid SHALL pulse for one cycle, stall SHALL drop, and the FSM SHALL return to IDLE.
REQ-021 Miss latency, from the request edge to ins_valid, SHALL be MEM_LATENCY+2 cycles.
REQ-022 While stall is high, pc_req and PC SHALL be ignored; the CPU re-issues its request after ins_valid.
REQ-023 A miss SHALL evict the resident line at that index unconditionally; there are no dirty lines.
REQ-024 flush in IDLE SHALL clear all valid bits on that edge; if pc_req is high in the same cycle, the request SHALL be treated as a miss.
REQ-025 flush during FILL or RESPOND SHALL clear all valid bits; the in-flight fill SHALL still complete and set its own line valid.
REQ-026 InsAddress SHALL hold its last value when not in FILL.
REQ-027 Instruction SHALL hold its last value when ins_valid is low.

Reset
REQ-028 While RST_N is low: state SHALL be IDLE; Instruction, InsAddress, ins_valid and stall SHALL be 0; all valid bits SHALL be cleared.
REQ-029 Reset asserted mid-FILL SHALL abandon the fill; no line SHALL be written and no ins_valid SHALL be produced.
REQ-030 Tag and data storage SHALL need no reset.

Structure
REQ-031 A shared package icache_pkg SHALL hold the FSM state enum, LINE_W=128, WORD_W=32 and WORDS_PER_LINE=4.
REQ-032 Valid, tag and data storage SHALL live in one sub-module, icache_tag_store (one read port, one write port); the FSM and latency counter SHALL stay in inst_fetch_cache.

Verification
REQ-033 Cold miss: after reset, pc_req with PC=0x0 and MEM_LATENCY=1 -> InsAddress=0, stall high for 2 cycles, ins_valid at cycle 3, Instruction=dataline[31:0].
REQ-034 Hit: next, PC=0x8 -> ins_valid 1 cycle later, Instruction=word 2 of line 0, stall never high, InsAddress unchanged.
REQ-035 Conflict: PC=0x40 (NUM_LINES=4) -> miss, InsAddress=4; a subsequent PC=0x0 -> miss again with InsAddress=0.
REQ-036 Flush: after line 0 is filled, flush=1 plus pc_req with PC=0x4 in the same cycle -> treated as a miss, refill from InsAddress=0, Instruction=word 1.
REQ-037 Reset mid-fill: RST_N low during FILL -> all outputs 0 immediately; after release, PC=0x10 -> cold miss with InsAddress=1.
REQ-038 Stall ignore: a PC change and pc_req pulses during FILL -> no effect; the response returns the originally latched word.
